// File: rtl/fifo_pkg.sv
// Shared defaults, width helper and reset constants for the FIFO controller slice.
package fifo_pkg;

    localparam int unsigned DEF_MEM_WIDTH       = 16;
    localparam int unsigned DEF_ADDER_SIZE      = 10;
    localparam int unsigned DEF_MEM_DEPTH       = 1024;
    localparam int unsigned DEF_ALMOST_FULL_TH  = 1020;
    localparam int unsigned DEF_ALMOST_EMPTY_TH = 4;

    localparam logic RST_DOUT_VALID = 1'b0;
    localparam logic RST_OVERFLOW   = 1'b0;
    localparam logic RST_UNDERFLOW  = 1'b0;

    // One extra bit so the count can represent a completely full FIFO.
    function automatic int unsigned count_width(input int unsigned adder_size);
        return adder_size + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping RAM address pointer with enable and synchronous reset.
module fifo_ptr #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] ptr
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] ptr_q;

    // Wraps to zero through natural overflow of the WIDTH-bit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (en) begin
            ptr_q <= ptr_q + ONE;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving a dual-port RAM; tracks occupancy and status flags.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned MEM_WIDTH       = DEF_MEM_WIDTH,
    parameter int unsigned MEM_DEPTH       = DEF_MEM_DEPTH,
    parameter int unsigned ADDER_SIZE      = DEF_ADDER_SIZE,
    parameter int unsigned ALMOST_FULL_TH  = DEF_ALMOST_FULL_TH,
    parameter int unsigned ALMOST_EMPTY_TH = DEF_ALMOST_EMPTY_TH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [MEM_WIDTH-1:0]  fifo_din,
    input  logic                  pop,
    output logic [MEM_WIDTH-1:0]  ram_din,
    output logic [ADDER_SIZE-1:0] ram_addr_wr,
    output logic [ADDER_SIZE-1:0] ram_addr_rd,
    output logic                  ram_wr_en,
    output logic                  ram_rd_en,
    output logic                  ram_blk_select,
    output logic                  dout_valid,
    output logic [ADDER_SIZE:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned CW = count_width(ADDER_SIZE);

    localparam logic [CW-1:0] DEPTH_C = CW'(MEM_DEPTH);
    localparam logic [CW-1:0] AF_TH_C = CW'(ALMOST_FULL_TH);
    localparam logic [CW-1:0] AE_TH_C = CW'(ALMOST_EMPTY_TH);
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0]         count_q, count_d;
    logic                  dout_valid_q, overflow_q, underflow_q;
    logic                  push_acc, pop_acc;
    logic [ADDER_SIZE-1:0] wr_ptr, rd_ptr;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_TH_C);
    assign almost_empty = (count_q <= AE_TH_C);

    // Requests are ignored outright while reset is held.
    assign push_acc = push & ~full & ~rst;
    assign pop_acc  = pop & ~empty & ~rst;

    assign ram_din        = fifo_din;
    assign ram_addr_wr    = wr_ptr;
    assign ram_addr_rd    = rd_ptr;
    assign ram_wr_en      = push_acc;
    assign ram_rd_en      = pop_acc;
    assign ram_blk_select = push_acc | pop_acc;

    fifo_ptr #(
        .WIDTH (ADDER_SIZE)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (push_acc),
        .ptr (wr_ptr)
    );

    fifo_ptr #(
        .WIDTH (ADDER_SIZE)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (pop_acc),
        .ptr (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        unique case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            dout_valid_q <= RST_DOUT_VALID;
            overflow_q   <= RST_OVERFLOW;
            underflow_q  <= RST_UNDERFLOW;
        end else begin
            count_q      <= count_d;
            // RAM captures read data on this same edge, so valid lines up with it.
            dout_valid_q <= pop_acc;
            overflow_q   <= push & full;
            underflow_q  <= pop & empty;
        end
    end

    assign count      = count_q;
    assign dout_valid = dout_valid_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a behavioural RAM and a queue-based reference model.
module tb_fifo_ctrl;

    localparam int W     = 16;
    localparam int AW    = 10;
    localparam int CW    = 11;
    localparam int DEPTH = 1024;
    localparam int AF    = 1020;
    localparam int AE    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [W-1:0]  fifo_din = '0;
    logic [W-1:0]  ram_din;
    logic [AW-1:0] ram_addr_wr, ram_addr_rd;
    logic          ram_wr_en, ram_rd_en, ram_blk_select;
    logic          dout_valid;
    logic [CW-1:0] count;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;

    fifo_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .push           (push),
        .fifo_din       (fifo_din),
        .pop            (pop),
        .ram_din        (ram_din),
        .ram_addr_wr    (ram_addr_wr),
        .ram_addr_rd    (ram_addr_rd),
        .ram_wr_en      (ram_wr_en),
        .ram_rd_en      (ram_rd_en),
        .ram_blk_select (ram_blk_select),
        .dout_valid     (dout_valid),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM: write and read capture on the same edge.
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] ram_dout = '0;
    always @(posedge clk) begin
        if (ram_blk_select) begin
            if (ram_wr_en) mem[ram_addr_wr] <= ram_din;
            if (ram_rd_en) ram_dout <= mem[ram_addr_rd];
        end
    end

    // Reference model state.
    logic [W-1:0]  m_q[$];
    int            n_push = 0;
    int            n_pop = 0;
    logic          e_wr_en, e_rd_en, e_dv, e_ovf, e_unf;
    logic [AW-1:0] e_addr_wr, e_addr_rd;
    logic [W-1:0]  e_dout;
    logic          s_wr_en, s_rd_en, s_blk;
    logic [AW-1:0] s_addr_wr, s_addr_rd;
    logic [W-1:0]  s_din;

    int n_checks = 0;
    int n_fail = 0;

    // Drive one cycle of stimulus, sample combinational outputs mid-cycle,
    // advance the model on the edge and return 1 time unit after it.
    task automatic cycle(input logic p, input logic o, input logic [W-1:0] d);
        bit pa, oa;
        push = p;
        pop = o;
        fifo_din = d;
        pa = p && !rst && (m_q.size() < DEPTH);
        oa = o && !rst && (m_q.size() > 0);
        e_wr_en = pa;
        e_rd_en = oa;
        e_addr_wr = AW'(n_push % DEPTH);
        e_addr_rd = AW'(n_pop % DEPTH);
        @(negedge clk);
        s_wr_en = ram_wr_en;
        s_rd_en = ram_rd_en;
        s_blk = ram_blk_select;
        s_addr_wr = ram_addr_wr;
        s_addr_rd = ram_addr_rd;
        s_din = ram_din;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            n_push = 0;
            n_pop = 0;
            e_dv = 1'b0;
            e_ovf = 1'b0;
            e_unf = 1'b0;
        end else begin
            e_ovf = p && !pa;
            e_unf = o && !oa;
            e_dv = oa;
            if (oa) begin
                e_dout = m_q.pop_front();
                n_pop++;
            end
            if (pa) begin
                m_q.push_back(d);
                n_push++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(1'b1, 1'b1, W'($urandom()));
        cycle(1'b1, 1'b1, W'($urandom()));
        n_checks++;
        if (s_wr_en !== 1'b0 || s_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ram_en: wr_en=%b rd_en=%b expected 0 0", s_wr_en, s_rd_en);
        end
        n_checks++;
        if (count !== '0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", count);
        end
        n_checks++;
        if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
            n_fail++;
            $display("FAIL reset_flags: got e/f/ae/af=%b expected 1010",
                     {empty, full, almost_empty, almost_full});
        end
        n_checks++;
        if ({dout_valid, overflow, underflow} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_pulses: got dv/ovf/unf=%b expected 000",
                     {dout_valid, overflow, underflow});
        end
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, W'(i));
            n_checks++;
            if (s_wr_en !== 1'b1 || s_addr_wr !== AW'(i) || s_din !== W'(i)) begin
                n_fail++;
                $display("FAIL fill_write[%0d]: wr_en=%b addr=%0d din=%0d expected 1 %0d %0d",
                         i, s_wr_en, s_addr_wr, s_din, i, i);
            end
            n_checks++;
            if (count !== CW'(i + 1) || almost_full !== ((i + 1) >= AF) ||
                full !== ((i + 1) == DEPTH)) begin
                n_fail++;
                $display("FAIL fill_count[%0d]: count=%0d af=%b full=%b expected %0d %b %b",
                         i, count, almost_full, full, i + 1, (i + 1) >= AF, (i + 1) == DEPTH);
            end
        end
        cycle(1'b1, 1'b0, W'($urandom()));
        n_checks++;
        if (s_wr_en !== 1'b0 || s_blk !== 1'b0 || overflow !== 1'b1 || count !== CW'(DEPTH)) begin
            n_fail++;
            $display("FAIL fill_overflow: wr_en=%b blk=%b ovf=%b count=%0d expected 0 0 1 %0d",
                     s_wr_en, s_blk, overflow, count, DEPTH);
        end
        cycle(1'b0, 1'b0, '0);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_pulse_width: got %b expected 0", overflow);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, '0);
            n_checks++;
            if (s_rd_en !== 1'b1 || s_addr_rd !== AW'(i)) begin
                n_fail++;
                $display("FAIL drain_read[%0d]: rd_en=%b addr=%0d expected 1 %0d",
                         i, s_rd_en, s_addr_rd, i);
            end
            n_checks++;
            if (dout_valid !== 1'b1 || ram_dout !== W'(i)) begin
                n_fail++;
                $display("FAIL drain_data[%0d]: dv=%b dout=%0d expected 1 %0d",
                         i, dout_valid, ram_dout, i);
            end
            n_checks++;
            if (count !== CW'(DEPTH - 1 - i) || almost_empty !== ((DEPTH - 1 - i) <= AE)) begin
                n_fail++;
                $display("FAIL drain_count[%0d]: count=%0d ae=%b expected %0d %b",
                         i, count, almost_empty, DEPTH - 1 - i, (DEPTH - 1 - i) <= AE);
            end
        end
        n_checks++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_empty: got %b expected 1", empty);
        end
        cycle(1'b0, 1'b1, '0);
        n_checks++;
        if (s_rd_en !== 1'b0 || underflow !== 1'b1 || dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_underflow: rd_en=%b unf=%b dv=%b expected 0 1 0",
                     s_rd_en, underflow, dout_valid);
        end
        cycle(1'b0, 1'b0, '0);
        n_checks++;
        if (underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_pulse_width: got %b expected 0", underflow);
        end
    endtask

    task automatic test_simul();
        bit seen_wr_wrap = 0;
        bit seen_rd_wrap = 0;
        // Walk pointers near the top of the address space before the main run.
        for (int i = 0; i < 2 * DEPTH && (n_push % DEPTH) < 1000; i++) begin
            cycle(1'b1, 1'b1, W'($urandom()));
        end
        for (int i = 0; i < 10 && m_q.size() < 5; i++) begin
            cycle(1'b1, 1'b0, W'($urandom()));
        end
        n_checks++;
        if (count !== CW'(5)) begin
            n_fail++;
            $display("FAIL simul_setup_count: got %0d expected 5", count);
        end
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 1'b1, W'($urandom()));
            if (s_addr_wr == '0) seen_wr_wrap = 1;
            if (s_addr_rd == '0) seen_rd_wrap = 1;
            n_checks++;
            if (s_wr_en !== 1'b1 || s_rd_en !== 1'b1 || s_addr_wr !== e_addr_wr ||
                s_addr_rd !== e_addr_rd) begin
                n_fail++;
                $display("FAIL simul_ram[%0d]: wr=%b rd=%b aw=%0d ar=%0d expected 1 1 %0d %0d",
                         i, s_wr_en, s_rd_en, s_addr_wr, s_addr_rd, e_addr_wr, e_addr_rd);
            end
            n_checks++;
            if (count !== CW'(5) || dout_valid !== 1'b1 || ram_dout !== e_dout) begin
                n_fail++;
                $display("FAIL simul_data[%0d]: count=%0d dv=%b dout=%h expected 5 1 %h",
                         i, count, dout_valid, ram_dout, e_dout);
            end
        end
        n_checks++;
        if (!(seen_wr_wrap && seen_rd_wrap)) begin
            n_fail++;
            $display("FAIL simul_wrap: wr_wrap=%b rd_wrap=%b expected 1 1",
                     seen_wr_wrap, seen_rd_wrap);
        end
    endtask

    task automatic test_full_empty();
        for (int i = 0; i < 2 * DEPTH && m_q.size() < DEPTH; i++) begin
            cycle(1'b1, 1'b0, W'($urandom()));
        end
        cycle(1'b1, 1'b1, W'($urandom()));
        n_checks++;
        if (s_wr_en !== 1'b0 || s_rd_en !== 1'b1 || count !== CW'(DEPTH - 1) ||
            overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL full_both: wr=%b rd=%b count=%0d ovf=%b expected 0 1 %0d 1",
                     s_wr_en, s_rd_en, count, overflow, DEPTH - 1);
        end
        n_checks++;
        if (dout_valid !== 1'b1 || ram_dout !== e_dout) begin
            n_fail++;
            $display("FAIL full_both_data: dv=%b dout=%h expected 1 %h", dout_valid, ram_dout, e_dout);
        end
        for (int i = 0; i < 2 * DEPTH && m_q.size() > 0; i++) begin
            cycle(1'b0, 1'b1, '0);
        end
        cycle(1'b1, 1'b1, W'($urandom()));
        n_checks++;
        if (s_wr_en !== 1'b1 || s_rd_en !== 1'b0 || s_blk !== 1'b1 || count !== CW'(1) ||
            underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_both: wr=%b rd=%b blk=%b count=%0d unf=%b expected 1 0 1 1 1",
                     s_wr_en, s_rd_en, s_blk, count, underflow);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2 * DEPTH && m_q.size() < 301; i++) begin
            cycle(1'b1, 1'b0, W'($urandom()));
        end
        cycle(1'b0, 1'b1, '0);
        n_checks++;
        if (count !== CW'(300) || dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_setup: count=%0d dv=%b expected 300 1", count, dout_valid);
        end
        rst = 1'b1;
        cycle(1'b1, 1'b1, W'($urandom()));
        rst = 1'b0;
        n_checks++;
        if (dout_valid !== 1'b0 || count !== '0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_clear: dv=%b count=%0d empty=%b expected 0 0 1",
                     dout_valid, count, empty);
        end
        cycle(1'b1, 1'b0, W'($urandom()));
        n_checks++;
        if (s_wr_en !== 1'b1 || s_addr_wr !== '0 || count !== CW'(1)) begin
            n_fail++;
            $display("FAIL midreset_push: wr=%b addr=%0d count=%0d expected 1 0 1",
                     s_wr_en, s_addr_wr, count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            // Bias push/pop phases so occupancy sweeps both ends.
            bit p, o;
            if ((i / 200) % 2 == 0) begin
                p = ($urandom_range(0, 3) != 0);
                o = ($urandom_range(0, 3) == 0);
            end else begin
                p = ($urandom_range(0, 3) == 0);
                o = ($urandom_range(0, 3) != 0);
            end
            cycle(p, o, W'($urandom()));
            n_checks++;
            if ({s_wr_en, s_rd_en, s_blk} !== {e_wr_en, e_rd_en, e_wr_en | e_rd_en} ||
                s_addr_wr !== e_addr_wr || s_addr_rd !== e_addr_rd) begin
                n_fail++;
                $display("FAIL rand_ram[%0d]: en=%b aw=%0d ar=%0d expected %b %0d %0d", i,
                         {s_wr_en, s_rd_en, s_blk}, s_addr_wr, s_addr_rd,
                         {e_wr_en, e_rd_en, e_wr_en | e_rd_en}, e_addr_wr, e_addr_rd);
            end
            n_checks++;
            if (count !== CW'(m_q.size()) || full !== (m_q.size() == DEPTH) ||
                empty !== (m_q.size() == 0) || almost_full !== (m_q.size() >= AF) ||
                almost_empty !== (m_q.size() <= AE)) begin
                n_fail++;
                $display("FAIL rand_count[%0d]: count=%0d flags=%b expected %0d", i, count,
                         {full, empty, almost_full, almost_empty}, m_q.size());
            end
            n_checks++;
            if ({dout_valid, overflow, underflow} !== {e_dv, e_ovf, e_unf} ||
                (e_dv && ram_dout !== e_dout)) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: dv/ovf/unf=%b dout=%h expected %b %h", i,
                         {dout_valid, overflow, underflow}, ram_dout, {e_dv, e_ovf, e_unf}, e_dout);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_simul();
        test_full_empty();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Synchronous FIFO controller that sits directly upstream of the dual-port RAM and drives its write port and read port. It turns a push/pop handshake into RAM control signals: din, addr_wr, addr_rd, wr_en, rd_en and blk_select. It also tracks occupancy and raises status flags. Read data comes back from the RAM one clock later, and fifo_ctrl flags that returned word with dout_valid.

Parameters:
MEM_WIDTH, 16, data word width
MEM_DEPTH, 1024, number of entries; must equal 2**ADDER_SIZE
ADDER_SIZE, 10, RAM address width
ALMOST_FULL_TH, 1020, almost_full asserts when count >= this value
ALMOST_EMPTY_TH, 4, almost_empty asserts when count <= this value

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
push  in  1  request to write fifo_din
fifo_din  in  MEM_WIDTH  write data
pop  in  1  request to read one word
ram_din  out  MEM_WIDTH  RAM write data (fifo_din passed through combinationally)
ram_addr_wr  out  ADDER_SIZE  RAM write address (= wr_ptr)
ram_addr_rd  out  ADDER_SIZE  RAM read address (= rd_ptr)
ram_wr_en  out  1  RAM write enable (combinational)
ram_rd_en  out  1  RAM read enable (combinational)
ram_blk_select  out  1  RAM block select (combinational)
dout_valid  out  1  RAM dout holds the popped word this cycle
count  out  ADDER_SIZE+1  current occupancy, 0..MEM_DEPTH
full  out  1  count == MEM_DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= ALMOST_FULL_TH
almost_empty  out  1  count <= ALMOST_EMPTY_TH
overflow  out  1  registered one-cycle pulse: push was rejected
underflow  out  1  registered one-cycle pulse: pop was rejected

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, dout_valid=0, overflow=0, underflow=0. Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0.
- Accept rules, evaluated on current-cycle state:
  - push_acc = push & ~full
  - pop_acc = pop & ~empty
- RAM drive:
  - ram_wr_en = push_acc
  - ram_rd_en = pop_acc
  - ram_blk_select = push_acc | pop_acc
  - The RAM writes and captures read data on the same edge.
- Pointers: wr_ptr increments on push_acc; rd_ptr increments on pop_acc. Both wrap MEM_DEPTH-1 -> 0 through natural ADDER_SIZE overflow.
- Count update:
  - +1 on push_acc only
  - -1 on pop_acc only
  - unchanged when both or neither are accepted
- Simultaneous push and pop:
  - When full, the pop is accepted and the push is rejected (overflow=1 next cycle).
  - When empty, the push is accepted and the pop is rejected (underflow=1 next cycle).
  - Otherwise both are accepted.
- No same-address read/write collision is possible: a read needs count>0, a write needs count<MEM_DEPTH, so addr_rd == addr_wr only when the FIFO is empty or full.
- Read latency: dout_valid <= pop_acc (registered). The word is valid on RAM dout exactly one cycle after the pop is accepted, the same cycle dout_valid=1.
- Flags: full, empty, almost_full and almost_empty are combinational decodes of the registered count. No flag depends on push or pop in the same cycle.
- Reset mid-operation:
  - Pointers and count clear on the next edge.
  - A pending dout_valid is dropped (0 on the cycle after reset).
  - RAM contents are not cleared; the entries are treated as stale.
  - push and pop are ignored in any cycle where rst=1.

Decomposition:
- Shared package fifo_pkg holds:
  - the default widths and depth
  - a function giving the count width, ADDER_SIZE+1
  - the reset constants
- One optional sub-module, fifo_ptr: a wrapping pointer with enable and synchronous reset, instantiated once for write and once for read.
- The count and flag logic stay in fifo_ctrl.

Test Plan:
1. Reset: rst=1 for 2 cycles while push=1 and pop=1 -> count=0, empty=1, dout_valid=0, ram_wr_en=0, ram_rd_en=0.
2. Fill: 1024 consecutive pushes of data=index -> full=1 after push 1024, almost_full=1 from count 1020. The 1025th push gives ram_wr_en=0 and an overflow pulse the next cycle.
3. Drain: 1024 pops after the fill -> ram_addr_rd runs 0..1023, and dout equals the index one cycle after each pop with dout_valid=1. empty=1 at the end; a 1025th pop gives an underflow pulse.
4. Simultaneous push and pop with count=5 for 100 cycles -> count stays 5, and the pointers wrap past 1023 to 0 with data order preserved.
5. Push and pop together while full -> only the read is issued, count=1023. Push and pop together while empty -> only the write is issued, count=1.
6. Reset asserted with count=300 one cycle after a pop -> dout_valid=0 and count=0 on the next edge. A subsequent push then goes to ram_addr_wr=0.
